cpu_mem_arbiter: RTL and testbench

// Shares the single-port CPU data memory between three requesters: the CPU MEM stage, the external host, and the hash accelerator.
// - Grants at most one access per cycle.
// - Sequences 16-beat accelerator line reads into one 512-bit word.
// - Stalls the CPU pipeline when it loses arbitration.

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/cpu_mem_line_gather.sv | 60 ++++++
 rtl/cpu_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU data-memory arbiter: FSM states, requester ids and line width.
package cpu_mem_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_BURST
    } arb_state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_CPU,
        REQ_EX,
        REQ_ACC
    } req_id_t;

    localparam int unsigned LINE_W = 512;

endpackage

// File: rtl/cpu_mem_line_gather.sv
// Assembles accelerator burst beats into one line and pulses line_valid when the last beat lands.
module cpu_mem_line_gather
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_valid,
    input  logic [DATA_W-1:0] beat_data,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] asm_q, asm_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              valid_q, valid_d;
    logic              last_beat;

    // The published line only changes on completion, so it stays stable while the next one fills.
    always_comb begin
        asm_d     = asm_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        valid_d   = 1'b0;
        last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));
        if (beat_valid) begin
            asm_d[int'(cnt_q) * DATA_W +: DATA_W] = beat_data;
            if (last_beat) begin
                cnt_d   = '0;
                line_d  = asm_d;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            line_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            line_q  <= line_d;
            valid_q <= valid_d;
        end
    end

    assign line_data  = line_q;
    assign line_valid = valid_q;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-port data-memory arbiter for CPU, host and hash accelerator, with starvation
// protection and 16-beat accelerator line reads.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ex_req,
    input  logic              ex_wr,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_gnt,
    output logic [DATA_W-1:0] ex_rd_data,
    output logic              ex_rd_valid,
    input  logic              acc_req,
    input  logic              acc_wr,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [LINE_W-1:0] acc_rd_data,
    output logic              acc_rd_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned BEAT_W   = $clog2(BURST_LEN);
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_t          state_q, state_d;
    req_id_t             gnt_id;
    req_id_t             owner_q, owner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
    logic [STARVE_W-1:0] ex_starve_q, ex_starve_d;
    logic [STARVE_W-1:0] acc_starve_q, acc_starve_d;
    logic [DATA_W-1:0]   ex_rd_data_q;
    logic                ex_force, acc_force;

    // Arbitration: a starved requester overrides the fixed cpu > ex > acc order.
    always_comb begin
        ex_force  = ex_req && (ex_starve_q == STARVE_W'(STARVE_MAX));
        acc_force = acc_req && (acc_starve_q == STARVE_W'(STARVE_MAX));
        gnt_id    = REQ_NONE;
        if (state_q == ARB_IDLE) begin
            if (ex_force) begin
                gnt_id = REQ_EX;
            end else if (acc_force) begin
                gnt_id = REQ_ACC;
            end else if (cpu_req) begin
                gnt_id = REQ_CPU;
            end else if (ex_req) begin
                gnt_id = REQ_EX;
            end else if (acc_req) begin
                gnt_id = REQ_ACC;
            end
        end
    end

    assign cpu_gnt   = (gnt_id == REQ_CPU);
    assign ex_gnt    = (gnt_id == REQ_EX);
    assign acc_gnt   = (gnt_id == REQ_ACC);
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Memory drive and FSM next state. The grant cycle of an accel read issues beat 0;
    // ARB_BURST issues the remaining beats from the captured base address.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        acc_addr_d = acc_addr_q;
        owner_d    = REQ_NONE;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                unique case (gnt_id)
                    REQ_CPU: begin
                        mem_en    = 1'b1;
                        mem_wr    = cpu_wr;
                        mem_addr  = cpu_addr;
                        mem_wdata = cpu_wdata;
                    end
                    REQ_EX: begin
                        mem_en    = 1'b1;
                        mem_wr    = ex_wr;
                        mem_addr  = ex_addr;
                        mem_wdata = ex_wdata;
                    end
                    REQ_ACC: begin
                        mem_en    = 1'b1;
                        mem_wr    = acc_wr;
                        mem_addr  = acc_addr;
                        mem_wdata = acc_wdata;
                        if (!acc_wr) begin
                            state_d    = ARB_BURST;
                            beat_d     = BEAT_W'(1);
                            acc_addr_d = acc_addr;
                        end
                    end
                    default: ;
                endcase
                if (mem_en && !mem_wr) begin
                    owner_d = gnt_id;
                end
            end
            ARB_BURST: begin
                mem_en   = 1'b1;
                mem_addr = acc_addr_q + ADDR_W'(beat_q);
                owner_d  = REQ_ACC;
                if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                    state_d = ARB_IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        ex_starve_d = ex_starve_q;
        if (!ex_req || ex_gnt) begin
            ex_starve_d = '0;
        end else if (ex_starve_q != STARVE_W'(STARVE_MAX)) begin
            ex_starve_d = ex_starve_q + STARVE_W'(1);
        end

        acc_starve_d = acc_starve_q;
        if (!acc_req || acc_gnt) begin
            acc_starve_d = '0;
        end else if (acc_starve_q != STARVE_W'(STARVE_MAX)) begin
            acc_starve_d = acc_starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= REQ_NONE;
            beat_q       <= '0;
            acc_addr_q   <= '0;
            ex_starve_q  <= '0;
            acc_starve_q <= '0;
            ex_rd_data_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            acc_addr_q   <= acc_addr_d;
            ex_starve_q  <= ex_starve_d;
            acc_starve_q <= acc_starve_d;
            ex_rd_data_q <= ex_rd_data;
        end
    end

    // Read return is steered by the owner tag registered alongside the issued read.
    assign cpu_rdata   = (owner_q == REQ_CPU) ? mem_rdata : '0;
    assign ex_rd_valid = (owner_q == REQ_EX);
    assign ex_rd_data  = ex_rd_valid ? mem_rdata : ex_rd_data_q;

    cpu_mem_line_gather #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) u_line_gather (
        .clk        (clk),
        .rst        (rst),
        .beat_valid (owner_q == REQ_ACC),
        .beat_data  (mem_rdata),
        .line_data  (acc_rd_data),
        .line_valid (acc_rd_valid)
    );

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed self-checking bench for cpu_mem_arbiter with a 1-cycle-latency memory model.
module tb_cpu_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_wr;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic         cpu_gnt, cpu_stall;
    logic [31:0]  cpu_rdata;
    logic         ex_req, ex_wr;
    logic [15:0]  ex_addr;
    logic [31:0]  ex_wdata;
    logic         ex_gnt;
    logic [31:0]  ex_rd_data;
    logic         ex_rd_valid;
    logic         acc_req, acc_wr;
    logic [15:0]  acc_addr;
    logic [31:0]  acc_wdata;
    logic         acc_gnt;
    logic [511:0] acc_rd_data;
    logic         acc_rd_valid;
    logic         mem_en, mem_wr;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:65535];
    bit          written [0:65535];

    always #5 clk = ~clk;

    cpu_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_req      (cpu_req),
        .cpu_wr       (cpu_wr),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_stall    (cpu_stall),
        .cpu_rdata    (cpu_rdata),
        .ex_req       (ex_req),
        .ex_wr        (ex_wr),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_gnt       (ex_gnt),
        .ex_rd_data   (ex_rd_data),
        .ex_rd_valid  (ex_rd_valid),
        .acc_req      (acc_req),
        .acc_wr       (acc_wr),
        .acc_addr     (acc_addr),
        .acc_wdata    (acc_wdata),
        .acc_gnt      (acc_gnt),
        .acc_rd_data  (acc_rd_data),
        .acc_rd_valid (acc_rd_valid),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Unwritten locations read as addr - 0x40, so mem[0x40+i] = i.
    function automatic logic [31:0] mem_init(input logic [15:0] a);
        return {16'h0, a} - 32'h40;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_wr) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_wr) begin
            mem_rdata <= written[mem_addr] ? mem[mem_addr] : mem_init(mem_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ex_gnt, acc_gnt, mem_en} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_gnt_en: got %b expected 0000", {cpu_gnt, ex_gnt, acc_gnt, mem_en});
        end
        checks++;
        if ({ex_rd_valid, acc_rd_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 00", {ex_rd_valid, acc_rd_valid});
        end
        checks++;
        if (ex_rd_data !== 32'h0 || cpu_rdata !== 32'h0 || acc_rd_data !== 512'h0) begin
            failures++;
            $display("FAIL reset_rdata: ex %h cpu %h acc %h expected all 0", ex_rd_data, cpu_rdata,
                     acc_rd_data);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin
            failures++;
            $display("FAIL idle_mem_en: got %b expected 0", mem_en);
        end
    endtask

    task automatic test_ex_write_read();
        tick();
        ex_req = 1'b1; ex_wr = 1'b1; ex_addr = 16'h1234; ex_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({ex_gnt, mem_en, mem_wr} !== 3'b111 || mem_addr !== 16'h1234 ||
            mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ex_write_issue: gnt/en/wr %b addr %h data %h expected 111 1234 deadbeef",
                     {ex_gnt, mem_en, mem_wr}, mem_addr, mem_wdata);
        end
        tick();
        ex_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({ex_gnt, mem_wr, ex_rd_valid} !== 3'b100) begin
            failures++;
            $display("FAIL ex_read_issue: gnt/wr/valid %b expected 100", {ex_gnt, mem_wr, ex_rd_valid});
        end
        tick();
        ex_req = 1'b0;
        @(negedge clk);
        checks++;
        if (ex_rd_valid !== 1'b1 || ex_rd_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ex_read_return: valid %b data %h expected 1 deadbeef", ex_rd_valid, ex_rd_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ex_rd_valid !== 1'b0 || ex_rd_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ex_read_hold: valid %b data %h expected 0 deadbeef", ex_rd_valid, ex_rd_data);
        end
    endtask

    task automatic test_priority_and_line();
        logic [511:0] exp_line;
        logic [15:0]  exp_a;
        for (int i = 0; i < 16; i++) exp_line[32*i +: 32] = 32'(i);
        tick();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0100;
        ex_req  = 1'b1; ex_wr  = 1'b0; ex_addr  = 16'h0200;
        acc_req = 1'b1; acc_wr = 1'b0; acc_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ex_gnt, acc_gnt, cpu_stall} !== 4'b1000) begin
            failures++;
            $display("FAIL prio_cycle0: gnt c/e/a,stall %b expected 1000", {cpu_gnt, ex_gnt, acc_gnt, cpu_stall});
        end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ex_gnt, acc_gnt} !== 3'b010 || cpu_rdata !== 32'h0000_00C0) begin
            failures++;
            $display("FAIL prio_cycle1: gnt %b cpu_rdata %h expected 010 000000c0",
                     {cpu_gnt, ex_gnt, acc_gnt}, cpu_rdata);
        end
        tick();
        ex_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, ex_gnt, acc_gnt} !== 3'b001 || mem_addr !== 16'h0040) begin
            failures++;
            $display("FAIL prio_cycle2: gnt %b addr %h expected 001 0040", {cpu_gnt, ex_gnt, acc_gnt}, mem_addr);
        end
        checks++;
        if (ex_rd_valid !== 1'b1 || ex_rd_data !== 32'h0000_01C0) begin
            failures++;
            $display("FAIL prio_ex_return: valid %b data %h expected 1 000001c0", ex_rd_valid, ex_rd_data);
        end
        // CPU requests throughout the burst and must stall until the first idle cycle.
        for (int k = 1; k <= 20; k++) begin
            tick();
            acc_req  = 1'b0;
            acc_addr = 16'hBEEF;
            cpu_req  = (k <= 16);
            cpu_addr = 16'h0100;
            @(negedge clk);
            checks++;
            if (acc_rd_valid !== (k == 17)) begin
                failures++;
                $display("FAIL line_valid_k%0d: got %b expected %b", k, acc_rd_valid, k == 17);
            end
            checks++;
            if (cpu_stall !== (k <= 15) || cpu_gnt !== (k == 16)) begin
                failures++;
                $display("FAIL burst_stall_k%0d: stall %b gnt %b expected %b %b", k, cpu_stall, cpu_gnt,
                         k <= 15, k == 16);
            end
            if (k <= 15) begin
                exp_a = 16'h0040 + 16'(k);
                checks++;
                if (mem_en !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== exp_a) begin
                    failures++;
                    $display("FAIL burst_addr_k%0d: en %b wr %b addr %h expected 1 0 %h", k, mem_en,
                             mem_wr, mem_addr, exp_a);
                end
            end
            if (k == 17) begin
                checks++;
                if (acc_rd_data[31:0] !== 32'h0 || acc_rd_data[511:480] !== 32'hF ||
                    acc_rd_data !== exp_line) begin
                    failures++;
                    $display("FAIL line_data: got %h expected %h", acc_rd_data, exp_line);
                end
                checks++;
                if (cpu_rdata !== 32'h0000_00C0) begin
                    failures++;
                    $display("FAIL cpu_after_burst: got %h expected 000000c0", cpu_rdata);
                end
            end
        end
    endtask

    task automatic test_ex_starve();
        int losses = 0;
        bit got    = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0010;
        ex_req  = 1'b1; ex_wr  = 1'b0; ex_addr  = 16'h0020;
        for (int c = 0; c < 20 && !got; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            if (ex_gnt === 1'b1) begin
                got = 1'b1;
                checks++;
                if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0) begin
                    failures++;
                    $display("FAIL ex_starve_stall: stall %b gnt %b expected 1 0", cpu_stall, cpu_gnt);
                end
            end else begin
                losses++;
            end
        end
        checks++;
        if (!got || losses != 8) begin
            failures++;
            $display("FAIL ex_starve_losses: granted %b after %0d losses expected 1 after 8", got, losses);
        end
        tick();
        ex_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || ex_rd_valid !== 1'b1 || ex_rd_data !== 32'hFFFF_FFE0) begin
            failures++;
            $display("FAIL ex_starve_return: cpu_gnt %b valid %b data %h expected 1 1 ffffffe0",
                     cpu_gnt, ex_rd_valid, ex_rd_data);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_acc_starve();
        int losses = 0;
        bit got    = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0010;
        acc_req = 1'b1; acc_wr = 1'b1; acc_addr = 16'h0300; acc_wdata = 32'h0000_0055;
        for (int c = 0; c < 20 && !got; c++) begin
            if (c > 0) tick();
            @(negedge clk);
            if (acc_gnt === 1'b1) begin
                got = 1'b1;
                checks++;
                if (mem_wr !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 32'h55) begin
                    failures++;
                    $display("FAIL acc_write_issue: wr %b addr %h data %h expected 1 0300 00000055",
                             mem_wr, mem_addr, mem_wdata);
                end
            end else begin
                losses++;
            end
        end
        checks++;
        if (!got || losses != 8) begin
            failures++;
            $display("FAIL acc_starve_losses: granted %b after %0d losses expected 1 after 8", got, losses);
        end
        tick();
        acc_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_gnt !== 1'b1 || acc_rd_valid !== 1'b0 || mem[16'h0300] !== 32'h55) begin
            failures++;
            $display("FAIL acc_write_done: cpu_gnt %b line_valid %b mem %h expected 1 0 00000055",
                     cpu_gnt, acc_rd_valid, mem[16'h0300]);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        tick();
        acc_req = 1'b1; acc_wr = 1'b0; acc_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if (acc_gnt !== 1'b1) begin
            failures++;
            $display("FAIL rstburst_gnt: got %b expected 1", acc_gnt);
        end
        for (int k = 1; k <= 25; k++) begin
            tick();
            acc_req = 1'b0;
            rst     = (k == 5);
            @(negedge clk);
            checks++;
            if (acc_rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstburst_valid_k%0d: got %b expected 0", k, acc_rd_valid);
            end
            if (k == 5) begin
                checks++;
                if (mem_en !== 1'b1 || mem_addr !== 16'h0045) begin
                    failures++;
                    $display("FAIL rstburst_beat5: en %b addr %h expected 1 0045", mem_en, mem_addr);
                end
            end
            if (k == 6) begin
                checks++;
                if (mem_en !== 1'b0 || acc_rd_data !== 512'h0 || ex_rd_data !== 32'h0) begin
                    failures++;
                    $display("FAIL rstburst_after: en %b acc %h ex %h expected 0 0 0", mem_en,
                             acc_rd_data, ex_rd_data);
                end
            end
        end
    endtask

    task automatic test_wrap_burst();
        logic [511:0] exp_line;
        logic [15:0]  exp_a;
        for (int i = 0; i < 16; i++) begin
            exp_line[32*i +: 32] = (i < 8) ? 32'h0000_FFB8 + 32'(i) : 32'hFFFF_FFC0 + 32'(i - 8);
        end
        tick();
        acc_req = 1'b1; acc_wr = 1'b0; acc_addr = 16'hFFF8;
        @(negedge clk);
        checks++;
        if (acc_gnt !== 1'b1 || mem_addr !== 16'hFFF8) begin
            failures++;
            $display("FAIL wrap_gnt: gnt %b addr %h expected 1 fff8", acc_gnt, mem_addr);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            acc_req = 1'b0;
            @(negedge clk);
            if (k <= 15) begin
                exp_a = 16'hFFF8 + 16'(k);
                checks++;
                if (mem_addr !== exp_a) begin
                    failures++;
                    $display("FAIL wrap_addr_k%0d: got %h expected %h", k, mem_addr, exp_a);
                end
            end
            checks++;
            if (acc_rd_valid !== (k == 17)) begin
                failures++;
                $display("FAIL wrap_valid_k%0d: got %b expected %b", k, acc_rd_valid, k == 17);
            end
        end
        checks++;
        if (acc_rd_data !== exp_line) begin
            failures++;
            $display("FAIL wrap_line: got %h expected %h", acc_rd_data, exp_line);
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ex_req  = 1'b0; ex_wr  = 1'b0; ex_addr  = '0; ex_wdata  = '0;
        acc_req = 1'b0; acc_wr = 1'b0; acc_addr = '0; acc_wdata = '0;
        test_reset();
        test_ex_write_read();
        test_priority_and_line();
        test_ex_starve();
        test_acc_starve();
        test_reset_mid_burst();
        test_wrap_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
